// File: rtl/alu_seq_ctrl_pkg.sv
// Shared constants and types for the ALU micro-sequencer.
// Opcodes, flag bit positions, FSM state encoding.
package alu_seq_ctrl_pkg;

    localparam logic [2:0] ALUOP_AND = 3'b000;
    localparam logic [2:0] ALUOP_OR  = 3'b001;
    localparam logic [2:0] ALUOP_ADD = 3'b010;
    localparam logic [2:0] ALUOP_SUB = 3'b110;
    localparam logic [2:0] ALUOP_SLT = 3'b111;

    localparam int FLAG_ZERO  = 2;
    localparam int FLAG_CARRY = 1;
    localparam int FLAG_OVF   = 0;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_READ = 3'd1,
        S_EXEC = 3'd2,
        S_WB   = 3'd3,
        S_RESP = 3'd4
    } state_t;

    function automatic logic op_legal(input logic [2:0] op);
        logic ok;
        ok = 1'b0;
        case (op)
            ALUOP_AND, ALUOP_OR, ALUOP_ADD,
            ALUOP_SUB, ALUOP_SLT: ok = 1'b1;
            default:              ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/alu_seq_ctrl_if.sv
// Command/response channel between a requester and the sequencer.
// master = requester side, slave = sequencer side.
interface alu_seq_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [2:0]            cmd_op;
    logic [ADDR_WIDTH-1:0] cmd_rd;
    logic [ADDR_WIDTH-1:0] cmd_rs;
    logic [ADDR_WIDTH-1:0] cmd_rt;
    logic                  cmd_imm_en;
    logic [DATA_WIDTH-1:0] cmd_imm;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_result;
    logic [2:0]            rsp_flag;
    logic [ADDR_WIDTH-1:0] rsp_rd;
    logic                  rsp_err;

    modport master (
        output cmd_valid, cmd_op, cmd_rd, cmd_rs, cmd_rt,
        output cmd_imm_en, cmd_imm, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_result, rsp_flag,
        input  rsp_rd, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_rd, cmd_rs, cmd_rt,
        input  cmd_imm_en, cmd_imm, rsp_ready,
        output cmd_ready, rsp_valid, rsp_result, rsp_flag,
        output rsp_rd, rsp_err
    );

endinterface

// File: rtl/alu_seq_ctrl.sv
// Multi-cycle sequencer: read regs, drive ALU, write back, respond.
// Sole master of the register file and ALU.
module alu_seq_ctrl
    import alu_seq_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    alu_seq_ctrl_if.slave         bus,
    output logic [ADDR_WIDTH-1:0] rf_raddr1,
    output logic [ADDR_WIDTH-1:0] rf_raddr2,
    input  logic [DATA_WIDTH-1:0] rf_rdata1,
    input  logic [DATA_WIDTH-1:0] rf_rdata2,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    output logic                  rf_wen,
    output logic [DATA_WIDTH-1:0] alu_a,
    output logic [DATA_WIDTH-1:0] alu_b,
    output logic [2:0]            alu_op,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic [2:0]            alu_flag,
    output logic [CNT_WIDTH-1:0]  wb_count
);

    state_t state;
    state_t state_nxt;

    logic [2:0]            op;
    logic [ADDR_WIDTH-1:0] rd;
    logic [ADDR_WIDTH-1:0] rs;
    logic [ADDR_WIDTH-1:0] rt;
    logic                  imm_en;
    logic [DATA_WIDTH-1:0] imm;
    logic [DATA_WIDTH-1:0] op_a;
    logic [DATA_WIDTH-1:0] op_b;
    logic [DATA_WIDTH-1:0] result;
    logic [2:0]            flag;
    logic                  err;

    always_ff @(posedge clk) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: if (bus.cmd_valid) state_nxt = S_READ;
            S_READ: state_nxt = op_legal(op) ? S_EXEC : S_RESP;
            S_EXEC: state_nxt = S_WB;
            S_WB:   state_nxt = S_RESP;
            S_RESP: if (bus.rsp_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath strobes are decoded purely from state so reset kills them at once.
    always_comb begin
        bus.cmd_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        rf_raddr1     = '0;
        rf_raddr2     = '0;
        rf_waddr      = '0;
        rf_wdata      = '0;
        rf_wen        = 1'b0;
        alu_a         = '0;
        alu_b         = '0;
        alu_op        = '0;
        unique case (state)
            S_IDLE: bus.cmd_ready = 1'b1;
            S_READ: begin
                rf_raddr1 = rs;
                rf_raddr2 = rt;
            end
            S_EXEC: begin
                alu_a  = op_a;
                alu_b  = op_b;
                alu_op = op;
            end
            S_WB: begin
                rf_waddr = rd;
                rf_wdata = result;
                rf_wen   = (rd != '0);
            end
            S_RESP: bus.rsp_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            op       <= '0;
            rd       <= '0;
            rs       <= '0;
            rt       <= '0;
            imm_en   <= 1'b0;
            imm      <= '0;
            op_a     <= '0;
            op_b     <= '0;
            result   <= '0;
            flag     <= '0;
            err      <= 1'b0;
            wb_count <= '0;
        end else begin
            unique case (state)
                S_IDLE: if (bus.cmd_valid) begin
                    op     <= bus.cmd_op;
                    rd     <= bus.cmd_rd;
                    rs     <= bus.cmd_rs;
                    rt     <= bus.cmd_rt;
                    imm_en <= bus.cmd_imm_en;
                    imm    <= bus.cmd_imm;
                    err    <= 1'b0;
                end
                S_READ: begin
                    op_a <= rf_rdata1;
                    op_b <= imm_en ? imm : rf_rdata2;
                    if (!op_legal(op)) begin
                        err    <= 1'b1;
                        result <= '0;
                        flag   <= '0;
                    end
                end
                S_EXEC: begin
                    result <= alu_result;
                    flag   <= alu_flag;
                end
                S_WB: if (rf_wen) wb_count <= wb_count + CNT_WIDTH'(1);
                default: ;
            endcase
        end
    end

    assign bus.rsp_result = result;
    assign bus.rsp_flag   = flag;
    assign bus.rsp_rd     = rd;
    assign bus.rsp_err    = err;

endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
- Multi-cycle micro-sequencer that executes one register-register or register-immediate ALU command at a time.
- Per command: reads two source registers from the register file, drives the shared ALU, and writes the result back.
- Returns result, flags and status to the requester over a valid/ready response channel.
- Sits between a command source (test master or simple fetch unit) and the existing ALU/register-file datapath. It is the only master of both.

Parameters:
DATA_WIDTH, 32, datapath width
ADDR_WIDTH, 5, register address width (32 registers, r0 reads zero)
CNT_WIDTH, 16, width of completed-writeback counter

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous, active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  controller can accept command
cmd_op  in  3  ALU opcode (000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT)
cmd_rd  in  ADDR_WIDTH  destination register
cmd_rs  in  ADDR_WIDTH  source A register
cmd_rt  in  ADDR_WIDTH  source B register (ignored when cmd_imm_en=1)
cmd_imm_en  in  1  use cmd_imm as operand B
cmd_imm  in  DATA_WIDTH  immediate operand
rf_raddr1  out  ADDR_WIDTH  register read address A
rf_raddr2  out  ADDR_WIDTH  register read address B
rf_rdata1  in  DATA_WIDTH  read data A (combinational from address)
rf_rdata2  in  DATA_WIDTH  read data B (combinational from address)
rf_waddr  out  ADDR_WIDTH  write address
rf_wdata  out  DATA_WIDTH  write data
rf_wen  out  1  write enable, register file writes on rising edge
alu_a  out  DATA_WIDTH  ALU operand A
alu_b  out  DATA_WIDTH  ALU operand B
alu_op  out  3  ALU opcode
alu_result  in  DATA_WIDTH  ALU result (combinational)
alu_flag  in  3  {Zero, CarryOut, Overflow} (combinational)
rsp_valid  out  1  response available
rsp_ready  in  1  requester accepts response
rsp_result  out  DATA_WIDTH  result written back
rsp_flag  out  3  captured ALU flags
rsp_rd  out  ADDR_WIDTH  destination of completed command
rsp_err  out  1  illegal opcode, no write performed
wb_count  out  CNT_WIDTH  number of register writes performed, wraps

Behaviour:
- FSM states: IDLE, READ, EXEC, WB, RESP. Encoding is one-hot or binary; width is free.
- Reset (rst=0 at a clock edge):
  - state=IDLE; all latched command/operand/result registers=0; wb_count=0.
  - Response outputs are 0, including rsp_valid and rsp_err.
  - rf_wen, rf_* and alu_* outputs are 0.
  - Reset mid-command abandons the command with no write. rf_wen is decoded from state, so it is 0 from the first reset edge.
- IDLE:
  - cmd_ready=1; this is the only state where cmd_ready=1.
  - On cmd_valid=1, latch op/rd/rs/rt/imm_en/imm and go to READ.
- READ:
  - rf_raddr1=rs, rf_raddr2=rt.
  - Capture op_a=rf_rdata1 and op_b=(imm_en ? imm : rf_rdata2).
  - Legal opcode -> EXEC. Illegal opcode (011, 100, 101) -> RESP with err=1, result=0, flag=000.
- EXEC:
  - alu_a=op_a, alu_b=op_b, alu_op=op.
  - Capture alu_result and alu_flag, then go to WB.
- WB:
  - rf_waddr=rd, rf_wdata=captured result.
  - rf_wen=1 for exactly this cycle, unless rd=0, in which case rf_wen=0.
  - wb_count increments only when rf_wen=1.
  - Next state is RESP.
- RESP:
  - rsp_valid=1; rsp_* hold stable until rsp_ready=1, then go to IDLE.
  - rsp_result still reports the ALU result when rd=0.
- Timing: outside READ/EXEC/WB, rf_raddr*/alu_* are don't-care but are driven 0.
- Latency: command accepted at edge N -> rsp_valid high from cycle N+4 (READ N+1, EXEC N+2, WB N+3).
- Throughput: with rsp_ready tied high, a new command is accepted every 5 cycles.
- cmd_valid in non-IDLE states is ignored and is not latched.
- wb_count wraps from all-ones to 0.

Decomposition:
- Shared package holds:
  - Opcode constants ALUOP_AND/OR/ADD/SUB/SLT.
  - Flag bit indices FLAG_ZERO=2, FLAG_CARRY=1, FLAG_OVF=0.
  - State encoding constants.
- No sub-module required. The FSM and datapath latches fit in one module.
- An optional opcode-legality function lives in the package.

Test Plan:
- Preload r1=5, r2=7; ADD rd=3 -> rf_wen pulse with waddr=3, wdata=12 at cycle N+3; rsp_result=12, rsp_flag=000, rsp_valid at N+4.
- r1=3, r2=5; SUB rd=4 -> rsp_result=0xFFFFFFFE, rsp_flag=010; r4 reads back 0xFFFFFFFE.
- r1=0x80000000; SLT imm_en=1, imm=1, rd=6 -> rsp_result=1; r6=1; wb_count increments by 1.
- ADD with rd=0 -> rf_wen never asserts; rsp_result=sum; wb_count unchanged. Illegal op 011 -> rsp_err=1, rsp_result=0, no write.
- rsp_ready held low 3 cycles -> rsp_* stable, cmd_ready=0, cmd_valid ignored. Release -> IDLE next edge, new command accepted.
- rst=0 during EXEC -> next edge state IDLE, rf_wen stays 0, target register unchanged, wb_count=0, rsp_valid=0.
